// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM bus types: the 32-bit word and the four-way RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_latency_responder_pkg.sv
// Helpers for the latency responder: counter width, preload value, address legality.
package ram_latency_responder_pkg;
  import cpu_types_pkg::*;

  // Wide enough for the largest supported latency (15).
  localparam int CNT_W = 4;

  // Value loaded into the wait counter on entering WAIT; the last BUSY cycle sees zero.
  function automatic logic [CNT_W-1:0] lat_preload(input int unsigned lat);
    return (lat == 0) ? '0 : CNT_W'(lat - 1);
  endfunction

  // A byte address is usable only if word-aligned and inside the stored words.
  function automatic logic req_addr_ok(input word_t addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (32'(addr[31:2]) < depth);
  endfunction

endpackage

// File: rtl/ram_latency_responder_if.sv
// cpu_ram_if bundle: requester drives REN/WEN/addr/store, responder returns load/state.
interface cpu_ram_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_latency_responder_word_array.sv
// DEPTH x 32 storage with synchronous write and registered (read-first) read.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              wen,
  input  logic [ADDR_W-1:0] idx,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [DEPTH];

  // Plain array with a registered read and no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wen) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_latency_responder.sv
// Word-addressed RAM responder for the cpu_ram_if handshake with a programmable
// number of BUSY wait states before the single ACCESS cycle.
module ram_latency_responder
  import cpu_types_pkg::*;
  import ram_latency_responder_pkg::*;
#(
  parameter  int unsigned LAT    = 2,
  parameter  int unsigned DEPTH  = 1024,
  localparam int          ADDR_W = $clog2(DEPTH)
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    ERR  = 2'd3
  } fsm_t;

  localparam logic             NO_WAIT  = (LAT == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = lat_preload(LAT);

  fsm_t             state_q;
  ramstate_t        ramstate_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_wr_q;     // latched op: 1 = write, 0 = read
  word_t            addr_q;      // latched byte address, compared every WAIT cycle
  word_t            data_q;      // write data captured at transaction start
  logic             show_rd_q;   // ramload currently shows the array's read register
  word_t            hold_q;      // last read result, shown once the read register moves on

  logic                req;
  logic                req_bad;
  logic                in_eval;
  logic                same_req;
  logic                enter_acc;
  logic                acc_write;
  logic                arr_wen;
  logic [ADDR_W-1:0]   arr_idx;
  word_t               arr_wdata;
  word_t               arr_rdata;

  // Request decode and the array access that happens on the edge entering ACC.
  // From IDLE/ACC/ERR the live inputs drive the array (zero-latency path);
  // from WAIT the latched transaction does, which is what keeps late ramstore
  // changes out of memory.
  always_comb begin
    req       = ramREN | ramWEN;
    req_bad   = (ramREN & ramWEN) | ~req_addr_ok(ramaddr, DEPTH);
    in_eval   = (state_q != WAIT);
    same_req  = (op_wr_q ? (ramWEN & ~ramREN) : (ramREN & ~ramWEN)) &&
                (ramaddr == addr_q);
    if (in_eval) begin
      enter_acc = req & ~req_bad & NO_WAIT;
      acc_write = ramWEN;
      arr_idx   = ramaddr[ADDR_W+1:2];
      arr_wdata = ramstore;
    end else begin
      enter_acc = same_req & (cnt_q == '0);
      acc_write = op_wr_q;
      arr_idx   = addr_q[ADDR_W+1:2];
      arr_wdata = data_q;
    end
    arr_wen = enter_acc & acc_write;
  end

  ram_word_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .CLK   (CLK),
    .wen   (arr_wen),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Handshake FSM, wait counter, transaction latch and read-data hold register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ramstate_q <= FREE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      show_rd_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      // Keep the visible read value when a write or idle cycle follows a read.
      if (show_rd_q) begin
        hold_q <= arr_rdata;
      end
      show_rd_q <= enter_acc & ~acc_write;

      case (state_q)
        WAIT: begin
          if (!same_req) begin
            state_q    <= IDLE;
            ramstate_q <= FREE;
          end else if (cnt_q == '0) begin
            state_q    <= ACC;
            ramstate_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          if (!req) begin
            state_q    <= IDLE;
            ramstate_q <= FREE;
          end else if (req_bad) begin
            state_q    <= ERR;
            ramstate_q <= ERROR;
          end else begin
            op_wr_q <= ramWEN;
            addr_q  <= ramaddr;
            data_q  <= ramstore;
            if (NO_WAIT) begin
              state_q    <= ACC;
              ramstate_q <= ACCESS;
            end else begin
              state_q    <= WAIT;
              ramstate_q <= BUSY;
              cnt_q      <= CNT_INIT;
            end
          end
        end
      endcase
    end
  end

  // Both sources are registers; the select only picks which one is current.
  assign ramload  = show_rd_q ? arr_rdata : hold_q;
  assign ramstate = ramstate_q;

endmodule
